// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: defaults, FSM states and the in-flight prediction entry.
package branch_resolver_pkg;

   localparam int unsigned BR_ADDR_W       = 8;
   localparam int unsigned BR_FIFO_DEPTH   = 4;
   localparam int unsigned BR_FLUSH_CYCLES = 2;
   localparam int unsigned BR_CNT_W        = 16;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } br_state_e;

   // One prediction issued at fetch and waiting for EX to resolve it.
   typedef struct packed {
      logic [BR_ADDR_W-1:0] pc;
      logic                 pred;
      logic [BR_ADDR_W-1:0] target;
   } pred_entry_t;

   localparam int unsigned PRED_ENTRY_W = $bits(pred_entry_t);

endpackage

// File: rtl/branch_resolver_fifo.sv
// Synchronous FIFO of in-flight predictions with push/pop/clear; push while full is only taken with a pop.
module branch_resolver_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en;
   logic              rd_en;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign data_o  = mem_q[rptr_q];
   assign wr_en   = push_i & (~full_o | pop_i) & ~clear_i;
   assign rd_en   = pop_i & ~empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (wr_en) wptr_d = wptr_q + PTR_W'(1);
         if (rd_en) rptr_d = rptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: checks the oldest queued prediction against the actual outcome,
// updates the predictor, redirects/flushes on a mispredict and keeps saturating statistics.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = BR_FIFO_DEPTH,
   parameter int unsigned FLUSH_CYCLES = BR_FLUSH_CYCLES,
   parameter int unsigned CNT_W        = BR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if_push_i,
   input  logic [BR_ADDR_W-1:0] if_pc_i,
   input  logic                 if_prediction_i,
   input  logic [BR_ADDR_W-1:0] if_pred_target_i,
   input  logic                 ex_resolve_i,
   input  logic                 ex_taken_i,
   input  logic [BR_ADDR_W-1:0] ex_target_i,
   output logic                 fifo_full_o,
   output logic                 update_predictor_o,
   output logic [BR_ADDR_W-1:0] upd_pc_o,
   output logic                 branch_taken_o,
   output logic [BR_ADDR_W-1:0] branch_addr_o,
   output logic                 redirect_valid_o,
   output logic [BR_ADDR_W-1:0] redirect_pc_o,
   output logic                 flush_o,
   output logic                 seq_err_o,
   output logic [CNT_W-1:0]     branch_count_o,
   output logic [CNT_W-1:0]     mispredict_count_o
);

   localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   br_state_e            state_q, state_d;
   logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
   logic                 flush_q, flush_d;
   logic                 upd_q, upd_d;
   logic [BR_ADDR_W-1:0] upc_q, upc_d;
   logic                 btaken_q, btaken_d;
   logic [BR_ADDR_W-1:0] baddr_q, baddr_d;
   logic                 rvalid_q, rvalid_d;
   logic [BR_ADDR_W-1:0] rpc_q, rpc_d;
   logic                 seq_err_q, seq_err_d;
   logic [CNT_W-1:0]     bcnt_q, bcnt_d;
   logic [CNT_W-1:0]     mcnt_q, mcnt_d;

   logic                 fifo_push, fifo_pop, fifo_clear;
   logic                 fifo_full, fifo_empty;
   logic                 accept;
   logic                 mispred;
   pred_entry_t          push_entry;
   pred_entry_t          head;

   assign push_entry  = '{pc: if_pc_i, pred: if_prediction_i, target: if_pred_target_i};
   assign fifo_full_o = fifo_full;

   branch_resolver_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (PRED_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .clear_i (fifo_clear),
      .data_i  (push_entry),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state, queue control and result computation.
   always_comb begin
      state_d    = state_q;
      fcnt_d     = fcnt_q;
      flush_d    = flush_q;
      upd_d      = 1'b0;
      rvalid_d   = 1'b0;
      upc_d      = upc_q;
      btaken_d   = btaken_q;
      baddr_d    = baddr_q;
      rpc_d      = rpc_q;
      seq_err_d  = seq_err_q;
      bcnt_d     = bcnt_q;
      mcnt_d     = mcnt_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      accept     = 1'b0;
      mispred    = 1'b0;

      case (state_q)
         S_IDLE: begin
            flush_d   = 1'b0;
            accept    = ex_resolve_i & ~fifo_empty;
            fifo_pop  = accept;
            fifo_push = if_push_i;
            if ((if_push_i & fifo_full & ~accept) | (ex_resolve_i & fifo_empty)) begin
               seq_err_d = 1'b1;
            end
            if (accept) begin
               mispred  = (head.pred != ex_taken_i) |
                          (head.pred & ex_taken_i & (head.target != ex_target_i));
               upd_d    = 1'b1;
               upc_d    = head.pc;
               btaken_d = ex_taken_i;
               baddr_d  = ex_target_i;
               rpc_d    = ex_taken_i ? ex_target_i : head.pc + BR_ADDR_W'(1);
               bcnt_d   = (bcnt_q == {CNT_W{1'b1}}) ? bcnt_q : bcnt_q + CNT_W'(1);
               if (mispred) begin
                  mcnt_d     = (mcnt_q == {CNT_W{1'b1}}) ? mcnt_q : mcnt_q + CNT_W'(1);
                  rvalid_d   = 1'b1;
                  flush_d    = 1'b1;
                  fifo_clear = 1'b1;
                  state_d    = S_FLUSH;
                  fcnt_d     = FCNT_W'(FLUSH_CYCLES - 1);
               end
            end
         end
         S_FLUSH: begin
            // Wrong-path pushes and resolves are dropped silently here.
            if (fcnt_q == '0) begin
               state_d = S_IDLE;
               flush_d = 1'b0;
            end else begin
               fcnt_d = fcnt_q - FCNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            flush_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         fcnt_q    <= '0;
         flush_q   <= 1'b0;
         upd_q     <= 1'b0;
         upc_q     <= '0;
         btaken_q  <= 1'b0;
         baddr_q   <= '0;
         rvalid_q  <= 1'b0;
         rpc_q     <= '0;
         seq_err_q <= 1'b0;
         bcnt_q    <= '0;
         mcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         fcnt_q    <= fcnt_d;
         flush_q   <= flush_d;
         upd_q     <= upd_d;
         upc_q     <= upc_d;
         btaken_q  <= btaken_d;
         baddr_q   <= baddr_d;
         rvalid_q  <= rvalid_d;
         rpc_q     <= rpc_d;
         seq_err_q <= seq_err_d;
         bcnt_q    <= bcnt_d;
         mcnt_q    <= mcnt_d;
      end
   end

   assign update_predictor_o = upd_q;
   assign upd_pc_o           = upc_q;
   assign branch_taken_o     = btaken_q;
   assign branch_addr_o      = baddr_q;
   assign redirect_valid_o   = rvalid_q;
   assign redirect_pc_o      = rpc_q;
   assign flush_o            = flush_q;
   assign seq_err_o          = seq_err_q;
   assign branch_count_o     = bcnt_q;
   assign mispredict_count_o = mcnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: queue-based reference model checked every cycle, plus directed literal checks.
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned FC    = 2;

   logic clk;
   logic rst_n;
   logic if_push, if_pred, ex_resolve, ex_taken;
   logic [7:0] if_pc, if_tgt, ex_target;

   logic        full, upd, btk, rv, fl, seq;
   logic [7:0]  upc, baddr, rpc;
   logic [15:0] bc, mc;
   logic        s_full, s_upd, s_btk, s_rv, s_fl, s_seq;
   logic [7:0]  s_upc, s_baddr, s_rpc;
   logic [1:0]  s_bc, s_mc;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 0;

   branch_resolver dut (
      .clk(clk), .rst_n(rst_n), .if_push_i(if_push), .if_pc_i(if_pc), .if_prediction_i(if_pred),
      .if_pred_target_i(if_tgt), .ex_resolve_i(ex_resolve), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
      .fifo_full_o(full), .update_predictor_o(upd), .upd_pc_o(upc), .branch_taken_o(btk),
      .branch_addr_o(baddr), .redirect_valid_o(rv), .redirect_pc_o(rpc), .flush_o(fl),
      .seq_err_o(seq), .branch_count_o(bc), .mispredict_count_o(mc));

   // Narrow-counter instance to reach saturation quickly.
   branch_resolver #(.CNT_W(2)) sat_dut (
      .clk(clk), .rst_n(rst_n), .if_push_i(if_push), .if_pc_i(if_pc), .if_prediction_i(if_pred),
      .if_pred_target_i(if_tgt), .ex_resolve_i(ex_resolve), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
      .fifo_full_o(s_full), .update_predictor_o(s_upd), .upd_pc_o(s_upc), .branch_taken_o(s_btk),
      .branch_addr_o(s_baddr), .redirect_valid_o(s_rv), .redirect_pc_o(s_rpc), .flush_o(s_fl),
      .seq_err_o(s_seq), .branch_count_o(s_bc), .mispredict_count_o(s_mc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of predictions and a flush countdown.
   typedef struct {
      logic [7:0] pc;
      logic       pred;
      logic [7:0] tgt;
   } ent_t;

   ent_t mq[$];
   int   flush_left = 0;
   int   e_bc = 0, e_mc = 0, e_bc2 = 0, e_mc2 = 0;
   logic e_upd = 0, e_bt = 0, e_rv = 0, e_flush = 0, e_seq = 0;
   logic [7:0] e_upc = 0, e_ba = 0, e_rpc = 0;

   always @(posedge clk) begin : model
      ent_t h;
      bit popok, pushok, mis;
      if (!rst_n) begin
         mq.delete();
         flush_left = 0;
         e_bc = 0; e_mc = 0; e_bc2 = 0; e_mc2 = 0;
         e_upd = 0; e_bt = 0; e_rv = 0; e_flush = 0; e_seq = 0;
         e_upc = 0; e_ba = 0; e_rpc = 0;
      end else begin
         e_upd = 0;
         e_rv  = 0;
         if (flush_left > 0) begin
            flush_left--;
            e_flush = (flush_left > 0);
         end else begin
            popok  = ex_resolve && mq.size() > 0;
            pushok = if_push && (mq.size() < DEPTH || popok);
            if ((ex_resolve && mq.size() == 0) || (if_push && !pushok)) e_seq = 1;
            mis = 0;
            if (popok) begin
               h = mq.pop_front();
               mis = (h.pred != ex_taken) || (h.pred && ex_taken && h.tgt != ex_target);
               e_upd = 1;
               e_upc = h.pc;
               e_bt  = ex_taken;
               e_ba  = ex_target;
               e_rpc = ex_taken ? ex_target : 8'((int'(h.pc) + 1) % 256);
               if (e_bc < 65535) e_bc++;
               if (e_bc2 < 3) e_bc2++;
               if (mis) begin
                  if (e_mc < 65535) e_mc++;
                  if (e_mc2 < 3) e_mc2++;
                  e_rv = 1;
                  e_flush = 1;
                  flush_left = FC;
                  mq.delete();
               end
            end
            if (pushok && !mis) mq.push_back('{pc: if_pc, pred: if_pred, tgt: if_tgt});
         end
      end
   end

   // Cycle-by-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("fifo_full", 32'(full), 32'(mq.size() == DEPTH));
         chk("update_predictor", 32'(upd), 32'(e_upd));
         chk("upd_pc", 32'(upc), 32'(e_upc));
         chk("branch_taken", 32'(btk), 32'(e_bt));
         chk("branch_addr", 32'(baddr), 32'(e_ba));
         chk("redirect_valid", 32'(rv), 32'(e_rv));
         chk("redirect_pc", 32'(rpc), 32'(e_rpc));
         chk("flush", 32'(fl), 32'(e_flush));
         chk("seq_err", 32'(seq), 32'(e_seq));
         chk("branch_count", 32'(bc), 32'(e_bc));
         chk("mispredict_count", 32'(mc), 32'(e_mc));
         chk("sat_branch_count", 32'(s_bc), 32'(e_bc2));
         chk("sat_mispredict_count", 32'(s_mc), 32'(e_mc2));
      end
   end

   task automatic cyc(input bit push, input logic [7:0] pc, input bit pred, input logic [7:0] tgt,
                      input bit res, input bit tk, input logic [7:0] et);
      if_push = push; if_pc = pc; if_pred = pred; if_tgt = tgt;
      ex_resolve = res; ex_taken = tk; ex_target = et;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_push = 0; if_pc = 0; if_pred = 0; if_tgt = 0;
      ex_resolve = 0; ex_taken = 0; ex_target = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_fifo_full", 32'(full), 32'd0);
      chk("reset_flush", 32'(fl), 32'd0);
      chk("reset_branch_count", 32'(bc), 32'd0);
      chk("reset_seq_err", 32'(seq), 32'd0);
      started = 1;
      rst_n = 1'b1;

      // Correct taken prediction.
      cyc(1, 8'h10, 1, 8'h20, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 8'h00, 1, 1, 8'h20);
      chk("t1_update", 32'(upd), 32'd1);
      chk("t1_upd_pc", 32'(upc), 32'h10);
      chk("t1_redirect", 32'(rv), 32'd0);
      chk("t1_flush", 32'(fl), 32'd0);
      chk("t1_branch_count", 32'(bc), 32'd1);
      idle();

      // Predicted not-taken, actually taken.
      cyc(1, 8'h10, 0, 8'h00, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 8'h00, 1, 1, 8'h30);
      chk("t2_redirect_pc", 32'(rpc), 32'h30);
      chk("t2_redirect_valid", 32'(rv), 32'd1);
      chk("t2_flush_c1", 32'(fl), 32'd1);
      chk("t2_mispredict_count", 32'(mc), 32'd1);
      idle();
      chk("t2_redirect_pulse", 32'(rv), 32'd0);
      chk("t2_flush_c2", 32'(fl), 32'd1);
      idle();
      chk("t2_flush_end", 32'(fl), 32'd0);

      // Fall-through PC wraps.
      cyc(1, 8'hFF, 1, 8'h05, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      chk("t3_redirect_pc_wrap", 32'(rpc), 32'h00);
      chk("t3_redirect_valid", 32'(rv), 32'd1);
      idle();
      idle();

      // Fill, push+pop when full, overflow push.
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h40 + i), 0, 8'h00, 0, 0, 8'h00);
      chk("t4_full", 32'(full), 32'd1);
      cyc(1, 8'h50, 0, 8'h00, 1, 0, 8'h00);
      chk("t4_full_after_pushpop", 32'(full), 32'd1);
      chk("t4_upd_pc", 32'(upc), 32'h40);
      cyc(1, 8'h60, 0, 8'h00, 0, 0, 8'h00);
      chk("t4_seq_err", 32'(seq), 32'd1);
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      chk("t4_last_pc", 32'(upc), 32'h50);
      chk("t4_empty", 32'(full), 32'd0);
      do_reset();
      chk("t4_seq_err_reset", 32'(seq), 32'd0);

      // Mispredict with queued entries and a simultaneous push.
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h41 + i), 0, 8'h00, 0, 0, 8'h00);
      cyc(1, 8'h44, 0, 8'h00, 1, 1, 8'h60);
      chk("t5_flush", 32'(fl), 32'd1);
      cyc(1, 8'h77, 1, 8'h11, 1, 0, 8'h00);
      cyc(1, 8'h78, 1, 8'h11, 1, 0, 8'h00);
      chk("t5_flush_done", 32'(fl), 32'd0);
      chk("t5_seq_err", 32'(seq), 32'd0);
      cyc(1, 8'h70, 0, 8'h00, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      chk("t5_queue_cleared", 32'(upc), 32'h70);
      chk("t5_seq_err_after", 32'(seq), 32'd0);
      chk("t5_branch_count", 32'(bc), 32'd2);

      // Reset in the middle of a flush.
      cyc(1, 8'h30, 1, 8'h40, 0, 0, 8'h00);
      cyc(0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      chk("t6_flush_before", 32'(fl), 32'd1);
      do_reset();
      chk("t6_flush_aborted", 32'(fl), 32'd0);
      chk("t6_branch_count", 32'(bc), 32'd0);
      chk("t6_mispredict_count", 32'(mc), 32'd0);

      // Counter saturation on the 2-bit instance.
      for (int i = 0; i < 4; i++) begin
         cyc(1, 8'h30, 1, 8'h40, 0, 0, 8'h00);
         cyc(0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
         idle();
         idle();
      end
      chk("t6_sat_branch", 32'(s_bc), 32'd3);
      chk("t6_sat_mispredict", 32'(s_mc), 32'd3);
      chk("t6_wide_branch", 32'(bc), 32'd4);
      chk("t6_wide_mispredict", 32'(mc), 32'd4);

      idle();
      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
